// File: rtl/snn_dma_pkg.sv
// Shared types and constants for the SRAM DMA initiator.
package snn_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_e;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } dma_mode_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/sram_dma_master.sv
// Single-channel word DMA: copy (alternating RD/WR, 2 cycles/word) or fill (1 write/cycle).
// SRAM port never stalls, so there is no backpressure; mem_req_* decode from registers only.
module sram_dma_master
  import snn_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [31:0]      fill_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_req_valid,
  output logic             mem_req_write,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  output logic [3:0]       mem_req_wstrb,
  input  logic [31:0]      mem_rdata
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  dma_state_e       r_state;
  dma_state_e       w_next_state;
  dma_mode_e        r_mode;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_fill;
  logic [31:0]      r_buf;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words_done;
  logic             r_err;

  logic             w_zero_len;
  logic             w_misaligned;
  logic [LEN_W-1:0] w_words_inc;
  logic             w_last;

  assign w_zero_len   = (len_words == '0);
  assign w_misaligned = (dst_addr[1:0] != 2'b00) ||
                        ((dma_mode_e'(mode) == COPY) && (src_addr[1:0] != 2'b00));
  assign w_words_inc  = r_words_done + LEN_ONE;
  assign w_last       = (w_words_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_zero_len || w_misaligned) begin
            w_next_state = DONE;
          end else if (dma_mode_e'(mode) == FILL) begin
            w_next_state = WR;
          end else begin
            w_next_state = RD;
          end
        end
      end
      RD:      w_next_state = abort ? DONE : WR;
      WR: begin
        if (w_last || abort) begin
          w_next_state = DONE;
        end else if (r_mode == FILL) begin
          w_next_state = WR;
        end else begin
          w_next_state = RD;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= COPY;
      r_src        <= '0;
      r_dst        <= '0;
      r_fill       <= '0;
      r_buf        <= '0;
      r_len        <= '0;
      r_words_done <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode       <= dma_mode_e'(mode);
            r_src        <= src_addr;
            r_dst        <= dst_addr;
            r_fill       <= fill_data;
            r_len        <= len_words;
            r_words_done <= '0;
            // A zero-length request completes cleanly even with a bad address.
            r_err        <= !w_zero_len && w_misaligned;
          end
        end
        RD: begin
          if (abort) begin
            r_err <= 1'b1;
          end else begin
            r_buf <= mem_rdata;
            r_src <= r_src + WORD_BYTES;
          end
        end
        WR: begin
          r_dst        <= r_dst + WORD_BYTES;
          r_words_done <= w_words_inc;
          if (abort && !w_last) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state == RD) || (r_state == WR);
  assign done          = (r_state == DONE);
  assign err           = r_err;
  assign words_done    = r_words_done;
  assign mem_req_valid = busy;
  assign mem_req_write = (r_state == WR);
  assign mem_req_addr  = (r_state == RD) ? r_src :
                         (r_state == WR) ? r_dst : 32'h0;
  assign mem_req_wdata = (r_state != WR) ? 32'h0 :
                         (r_mode == FILL) ? r_fill : r_buf;
  assign mem_req_wstrb = (r_state == WR) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_sram_dma_master.sv
// Bench for sram_dma_master: table of transfers, bus scoreboard, plus busy-start and mid-copy reset.
module tb_sram_dma_master;
  import snn_dma_pkg::*;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len_words;
  logic [31:0]      fill_data;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] words_done;
  logic             mem_req_valid;
  logic             mem_req_write;
  logic [31:0]      mem_req_addr;
  logic [31:0]      mem_req_wdata;
  logic [3:0]       mem_req_wstrb;
  logic [31:0]      mem_rdata;

  always #5 clk = ~clk;

  sram_dma_master #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len_words    (len_words),
    .fill_data    (fill_data),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_done   (words_done),
    .mem_req_valid(mem_req_valid),
    .mem_req_write(mem_req_write),
    .mem_req_addr (mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_rdata    (mem_rdata)
  );

  // 1 KiB word-addressed SRAM model; upper address bits alias.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_req_addr[9:2]];

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  typedef struct {
    logic             mode;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      fill;
    int               abort_cyc;
    int               glitch_cyc;
    logic [LEN_W-1:0] exp_words;
    logic             exp_err;
    int               exp_done_cyc;
  } vec_t;

  txn_t exp_q[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference bus sequence derived from the transfer description.
  task automatic build_expected(input vec_t v);
    logic [31:0] s, d, wd;
    int cyc, w;
    s = v.src; d = v.dst; cyc = 0; w = 0;
    if (v.len == 0 || v.dst[1:0] != 2'b00 || (v.mode == 1'b0 && v.src[1:0] != 2'b00)) return;
    forever begin
      if (v.mode == 1'b0) begin
        cyc++;
        exp_q.push_back('{1'b0, s, 32'h0, 4'h0});
        if (cyc == v.abort_cyc) return;
        wd = mem[s[9:2]];
        s  = s + 32'd4;
      end else begin
        wd = v.fill;
      end
      cyc++;
      exp_q.push_back('{1'b1, d, wd, 4'hF});
      d = d + 32'd4;
      w++;
      if (w == int'(v.len) || cyc == v.abort_cyc) return;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   done_cyc, busy_cnt;
    txn_t t;
    exp_q.delete();
    build_expected(v);
    @(negedge clk);
    start = 1'b1; mode = v.mode; src_addr = v.src; dst_addr = v.dst;
    len_words = v.len; fill_data = v.fill; abort = 1'b0;
    done_cyc = 0; busy_cnt = 0;
    for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      start = (cyc == v.glitch_cyc);
      if (cyc == v.glitch_cyc) begin
        mode = ~v.mode; src_addr = 32'h0; dst_addr = 32'h10; len_words = 1;
      end
      abort = (cyc == v.abort_cyc);
      if (busy) busy_cnt++;
      if (mem_req_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_req"}, mem_req_valid, 1'b0);
        end else begin
          t = exp_q.pop_front();
          chk({tag, "_req"}, {mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb}, t);
          if (mem_req_write) mem[mem_req_addr[9:2]] = mem_req_wdata;
        end
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0; abort = 1'b0;
    chk({tag, "_done_cyc"}, done_cyc, v.exp_done_cyc);
    chk({tag, "_busy_cyc"}, busy_cnt, v.exp_done_cyc - 1);
    chk({tag, "_words"}, words_done, v.exp_words);
    chk({tag, "_err"}, err, v.exp_err);
    chk({tag, "_missing_req"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_idle_done"}, {busy, done, mem_req_valid}, 3'b000);
    chk({tag, "_hold_words"}, words_done, v.exp_words);
    chk({tag, "_hold_err"}, err, v.exp_err);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len_words = '0; fill_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'h11 * (i + 1);
    for (int i = 0; i < 8; i++) mem[192 + i] = 32'hA000_0000 + i;

    // mode, src, dst, len, fill, abort_cyc, glitch_cyc, exp_words, exp_err, exp_done_cyc
    vecs[0] = '{1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 0, 0, 16'd4, 1'b0, 9};
    vecs[1] = '{1'b1, 32'h0, 32'h40, 16'd3, 32'hDEADBEEF, 0, 0, 16'd3, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h100, 32'h200, 16'd0, 32'h0, 0, 0, 16'd0, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h102, 32'h200, 16'd4, 32'h0, 0, 0, 16'd0, 1'b1, 1};
    vecs[4] = '{1'b1, 32'h0, 32'h42, 16'd3, 32'h5555AAAA, 0, 0, 16'd0, 1'b1, 1};
    vecs[5] = '{1'b1, 32'h103, 32'h60, 16'd2, 32'h0BADF00D, 0, 0, 16'd2, 1'b0, 3};
    vecs[6] = '{1'b0, 32'h300, 32'h380, 16'd8, 32'h0, 5, 0, 16'd2, 1'b1, 6};
    vecs[7] = '{1'b0, 32'h100, 32'h3C0, 16'd2, 32'h0, 4, 0, 16'd2, 1'b0, 5};
    vecs[8] = '{1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'hCAFEF00D, 0, 0, 16'd2, 1'b0, 3};
    vecs[9] = '{1'b1, 32'h0, 32'h80, 16'd5, 32'h12345678, 2, 0, 16'd2, 1'b1, 3};

    repeat (2) @(negedge clk);
    chk("reset_status", {busy, done, err, words_done}, '0);
    chk("reset_bus", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    for (int i = 0; i < 4; i++) chk($sformatf("copy_dst%0d", i), mem[128 + i], 32'h11 * (i + 1));

    // start pulsed mid-copy with different parameters must be ignored
    run_vec('{1'b0, 32'h100, 32'h220, 16'd4, 32'h0, 0, 3, 16'd4, 1'b0, 9}, "busy_start");

    // asynchronous reset in the middle of a copy
    @(negedge clk);
    start = 1'b1; mode = 1'b0; src_addr = 32'h100; dst_addr = 32'h240; len_words = 16'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_status", {busy, done, err, words_done}, '0);
    chk("arst_bus", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_wstrb}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dma_master.md
# sram_dma_master

Single-channel word-granular DMA initiator that drives the SoC's simple single-port SRAM request interface: one request per cycle, synchronous write, read data valid combinationally in the same cycle. Software or the SNN controller programs a source, destination and length, pulses start, and the block either copies memory-to-memory or fills a region with a constant pattern. It sits between the control register file and an SRAM instance, or an SRAM arbiter port, and replaces CPU-driven copy loops for loading weights and spike buffers.

## Interface
Parameters:
- LEN_W, 16, width of the word-count field; maximum transfer is 2^LEN_W − 1 words.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  32  byte address, copy source; ignored in fill mode.
- dst_addr  in  32  byte address, destination.
- len_words  in  LEN_W  number of 32-bit words to transfer.
- fill_data  in  32  pattern for fill mode.
- abort  in  1  stop the transfer at the next word boundary.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse in the DONE state.
- err  out  1  sticky; cleared by the next accepted start.
- words_done  out  LEN_W  count of words written in the current or last transfer.
- mem_req_valid  out  1  SRAM request valid.
- mem_req_write  out  1  1 = write, 0 = read.
- mem_req_addr  out  32  SRAM byte address.
- mem_req_wdata  out  32  write data.
- mem_req_wstrb  out  4  byte strobes; always 4'hF when writing, 4'h0 otherwise.
- mem_rdata  in  32  combinational read data from the SRAM.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, start=1: latch mode, src_addr, dst_addr, len_words and fill_data into internal registers; clear err and words_done.
  - If len_words = 0, go to DONE with no memory access.
  - If the low two bits of dst_addr are nonzero, or the low two bits of src_addr are nonzero in copy mode: set err and go to DONE with no memory access.
  - Otherwise go to RD in copy mode, or WR in fill mode.
- RD: drive a read at cur_src. Capture mem_rdata into a data buffer at the clock edge. Add 4 to cur_src. Go to WR.
- WR: drive a write at cur_dst with the buffer (copy) or fill_data (fill). Add 4 to cur_dst and 1 to words_done.
  - If words_done+1 = length, or abort=1: go to DONE.
  - Otherwise go to RD (copy) or stay in WR (fill).
- DONE: pulse done, then go to IDLE.
- Abort:
  - Sampled in RD or WR.
  - In RD, the pending read is discarded; go to DONE without writing, and set err.
  - In WR, the current write still completes; go to DONE and set err if words remain.
  - Ignored in IDLE and DONE.
- start outside IDLE is ignored. It is not queued.
- Address arithmetic is modulo 2^32 and wraps silently: 0xFFFFFFFC + 4 = 0x00000000.
- The mem_req_* outputs decode from the registered state and address/data registers only; there is no combinational path from inputs. mem_rdata is used only at the capture edge.

## Timing
- Reset values: state IDLE; busy, done, err = 0; words_done = 0; all mem_req_* = 0.
- An asynchronous reset mid-transfer returns to IDLE immediately. No further requests are issued, and any partially written region is left as-is.
- Copy of N words: 2N cycles busy, alternating RD and WR, followed by 1 DONE cycle. The first request is issued in the cycle after the start cycle.
- Fill of N words: N consecutive write cycles, then DONE.
- A zero-length or error start reaches DONE in the cycle after start, with mem_req_valid never asserted.
- busy = (state is RD or WR); it is low in DONE.
- A new start is accepted no earlier than the cycle after DONE, when the block is back in IDLE.
- words_done and err hold their values in IDLE until the next accepted start.

## Structure
- Shared package snn_dma_pkg:
  - typedef enum dma_state_e {IDLE, RD, WR, DONE};
  - typedef enum dma_mode_e {COPY, FILL};
  - constant WORD_BYTES = 4.
- A single module. No sub-module is warranted: the address and count registers and the FSM are small. The SRAM model is instantiated only in the testbench.

## Test plan
- Copy, len=4, src=0x100, dst=0x200, SRAM preloaded with 0x11..0x44: bus shows RD 0x100, WR 0x200, RD 0x104, … over 8 busy cycles; done pulses in cycle 9; dst words match; words_done=4; err=0.
- Fill, len=3, dst=0x40, fill_data=0xDEADBEEF: 3 back-to-back writes to 0x40, 0x44, 0x48 with wstrb=4'hF, no reads; done in cycle 4.
- Zero length and misaligned address:
  - len=0: done one cycle after start, mem_req_valid never high, err=0.
  - src=0x102 in copy mode: the same behaviour, but err=1.
- Abort:
  - Copy of len=8 with abort asserted during the 3rd RD: exactly 2 writes have occurred, words_done=2, err=1, done pulses next cycle.
  - Abort asserted in the final WR of the transfer: err=0.
- Wrap: fill len=2, dst=0xFFFFFFFC; writes go to 0xFFFFFFFC, then 0x00000000.
- Robustness:
  - start pulsed while busy is ignored; the first transfer completes unchanged.
  - rst_n asserted mid-copy: all outputs read 0 immediately, and a subsequent start runs normally.
